// File: rtl/gio_arb.sv
// Two-master round-robin Wishbone arbiter for the gio register bus, with a
// per-transfer watchdog that terminates unacknowledged cycles and counts them.
module gio_arb #(
  parameter int unsigned TMO_CYC = 15
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [3:0]  m0_sel,
  input  logic [7:0]  m0_adr,
  input  logic [31:0] m0_dat,
  output logic [31:0] m0_rdt,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [3:0]  m1_sel,
  input  logic [7:0]  m1_adr,
  input  logic [31:0] m1_dat,
  output logic [31:0] m1_rdt,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic [7:0]  s_adr,
  output logic [31:0] s_dat,
  input  logic [31:0] s_rdt,
  input  logic        s_ack,
  output logic [1:0]  grant,
  output logic [7:0]  tmo_cnt
);

  localparam logic [7:0] TmoCyc = 8'(TMO_CYC);

  typedef enum logic [1:0] {StIdle, StBus0, StBus1} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  wdog_q, wdog_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [1:0]  grant_q, grant_d;

  logic        busy, own1, req0, req1;
  logic        o_cyc, o_stb, o_we;
  logic [3:0]  o_sel;
  logic [7:0]  o_adr;
  logic [31:0] o_dat;
  logic        ack, tmo;

  assign busy = (state_q != StIdle);
  assign own1 = (state_q == StBus1);
  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;

  always_comb begin
    o_cyc = own1 ? m1_cyc : m0_cyc;
    o_stb = own1 ? m1_stb : m0_stb;
    o_we  = own1 ? m1_we  : m0_we;
    o_sel = own1 ? m1_sel : m0_sel;
    o_adr = own1 ? m1_adr : m0_adr;
    o_dat = own1 ? m1_dat : m0_dat;

    s_cyc = busy & o_cyc;
    s_stb = busy & o_stb;
    s_we  = busy & o_we;
    s_sel = busy ? o_sel : 4'h0;
    s_adr = busy ? o_adr : 8'h00;
    s_dat = busy ? o_dat : 32'h0;

    // An owner that has dropped cyc is aborting: it gets neither ack nor err.
    ack = busy & o_cyc & s_ack;
    tmo = busy & o_cyc & ~s_ack & (wdog_q == TmoCyc);

    m0_ack = ack & ~own1;
    m1_ack = ack & own1;
    m0_err = tmo & ~own1;
    m1_err = tmo & own1;
    m0_rdt = (ack & ~own1) ? s_rdt : 32'h0;
    m1_rdt = (ack & own1) ? s_rdt : 32'h0;
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    tmo_cnt_d = tmo_cnt_q;
    unique case (state_q)
      StIdle: begin
        // On contention the master that did not own the bus last wins.
        if (req0 && (!req1 || last_q)) begin
          state_d = StBus0;
          last_d  = 1'b0;
          wdog_d  = 8'h00;
        end else if (req1) begin
          state_d = StBus1;
          last_d  = 1'b1;
          wdog_d  = 8'h00;
        end
      end
      StBus0, StBus1: begin
        if (!o_cyc || ack || tmo) begin
          state_d = StIdle;
          if (tmo && tmo_cnt_q != 8'hFF) begin
            tmo_cnt_d = tmo_cnt_q + 8'h01;
          end
        end else begin
          wdog_d = wdog_q + 8'h01;
        end
      end
      default: state_d = StIdle;
    endcase
    grant_d = {state_d == StBus1, state_d == StBus0};
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      wdog_q    <= 8'h00;
      tmo_cnt_q <= 8'h00;
      grant_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      tmo_cnt_q <= tmo_cnt_d;
      grant_q   <= grant_d;
    end
  end

  assign grant   = grant_q;
  assign tmo_cnt = tmo_cnt_q;

endmodule
